wb_priority_arbiter: RTL and testbench

WB_PRIORITY_ARBITER -- requirements
Module: wb_priority_arbiter

---
 rtl/wb_priority_arbiter.sv | 99 +++++++++
 tb/tb_wb_priority_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_priority_arbiter.sv
// wb_priority_arbiter: nine-way write-back arbiter with a one-entry hold per unit
// and an age-based starvation override on top of fixed highest-index priority.
module wb_priority_arbiter #(
   parameter int XLEN      = 32,
   parameter int AGE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [8:0]        unit_done,
   input  logic [9*XLEN-1:0] unit_data,
   input  logic [9*5-1:0]    unit_rd,
   input  logic [8:0]        unit_fp,
   output logic [8:0]        unit_stall,
   output logic              wb_valid,
   output logic [XLEN-1:0]   wb_data,
   output logic [4:0]        wb_rd,
   output logic              wb_fp,
   output logic [8:0]        wb_unit,
   output logic              proto_err
);
   localparam logic [2:0] LIM = 3'(AGE_LIMIT);
   logic [8:0]      r_pend, r_hfp;
   logic [XLEN-1:0] r_hdata [9];
   logic [4:0]      r_hrd   [9];
   logic [2:0]      r_age   [9];
   logic [8:0]      w_req, w_starved, w_sel, w_gnt, w_src_fp;
   logic [XLEN-1:0] w_src_data [9];
   logic [4:0]      w_src_rd   [9];
   logic [XLEN-1:0] w_data;
   logic [4:0]      w_rd;
   logic            w_fp;

   assign w_req      = r_pend | (unit_done & ~r_pend);
   assign w_sel      = |w_starved ? w_starved : w_req;
   assign unit_stall = r_pend;

   // Held entries take precedence over live inputs for their own unit
   for (genvar i = 0; i < 9; i++) begin : g_src
      assign w_starved[i]  = r_pend[i] && (r_age[i] == LIM);
      assign w_src_data[i] = r_pend[i] ? r_hdata[i] : unit_data[XLEN*i +: XLEN];
      assign w_src_rd[i]   = r_pend[i] ? r_hrd[i] : unit_rd[5*i +: 5];
      assign w_src_fp[i]   = r_pend[i] ? r_hfp[i] : unit_fp[i];
   end

   always_comb begin
      w_gnt  = '0;
      w_data = '0;
      w_rd   = '0;
      w_fp   = 1'b0;
      for (int i = 0; i < 9; i++)
         if (w_sel[i]) begin
            w_gnt    = '0;
            w_gnt[i] = 1'b1;
            w_data   = w_src_data[i];
            w_rd     = w_src_rd[i];
            w_fp     = w_src_fp[i];
         end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend    <= '0;
         r_hfp     <= '0;
         wb_valid  <= 1'b0;
         wb_unit   <= '0;
         wb_data   <= '0;
         wb_rd     <= '0;
         wb_fp     <= 1'b0;
         proto_err <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            r_hdata[i] <= '0;
            r_hrd[i]   <= '0;
            r_age[i]   <= '0;
         end
      end else begin
         wb_valid <= |w_req;
         wb_unit  <= w_gnt;
         if (|w_req) begin
            wb_data <= w_data;
            wb_rd   <= w_rd;
            wb_fp   <= w_fp;
         end
         if (|(unit_done & r_pend)) proto_err <= 1'b1;
         for (int i = 0; i < 9; i++)
            if (w_gnt[i]) begin
               r_pend[i] <= 1'b0;
               r_age[i]  <= '0;
            end else if (r_pend[i]) begin
               r_age[i] <= (r_age[i] == LIM) ? LIM : r_age[i] + 3'd1;
            end else if (unit_done[i]) begin
               r_pend[i]  <= 1'b1;
               r_age[i]   <= 3'd1;
               r_hdata[i] <= unit_data[XLEN*i +: XLEN];
               r_hrd[i]   <= unit_rd[5*i +: 5];
               r_hfp[i]   <= unit_fp[i];
            end
      end
   end
endmodule

// File: tb/tb_wb_priority_arbiter.sv
// tb_wb_priority_arbiter: directed stimulus against a wait-time based reference
// model compared every cycle, plus literal expectations for the key scenarios.
module tb_wb_priority_arbiter;
   localparam int XLEN = 32;
   localparam int AGE  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [8:0]        unit_done = '0;
   logic [9*XLEN-1:0] unit_data = '0;
   logic [44:0]       unit_rd = '0;
   logic [8:0]        unit_fp = '0;
   logic [8:0]        unit_stall;
   logic              wb_valid;
   logic [XLEN-1:0]   wb_data;
   logic [4:0]        wb_rd;
   logic              wb_fp;
   logic [8:0]        wb_unit;
   logic              proto_err;

   int checks = 0;
   int errors = 0;

   bit              m_pend  [9];
   logic [XLEN-1:0] m_data  [9];
   logic [4:0]      m_rd    [9];
   bit              m_fp    [9];
   int              m_since [9];
   int              now = 0;
   logic            e_valid, e_fp, e_err;
   logic [XLEN-1:0] e_data;
   logic [4:0]      e_rd;
   logic [8:0]      e_unit;

   wb_priority_arbiter #(.XLEN(XLEN), .AGE_LIMIT(AGE)) dut (
      .clk(clk), .rst_n(rst_n), .unit_done(unit_done), .unit_data(unit_data),
      .unit_rd(unit_rd), .unit_fp(unit_fp), .unit_stall(unit_stall),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_fp(wb_fp),
      .wb_unit(wb_unit), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] m_pvec();
      logic [8:0] v = '0;
      for (int i = 0; i < 9; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) begin
         m_pend[i] = 0; m_data[i] = '0; m_rd[i] = '0; m_fp[i] = 0; m_since[i] = 0;
      end
      e_valid = 0; e_data = '0; e_rd = '0; e_fp = 0; e_unit = '0; e_err = 0;
   endtask

   // A unit captured at edge S has waited (now - S) edges; it is starved once that reaches AGE
   task automatic model_step();
      int g = -1;
      now++;
      for (int i = 8; i >= 0; i--)
         if (g < 0 && m_pend[i] && (now - m_since[i]) >= AGE) g = i;
      for (int i = 8; i >= 0; i--)
         if (g < 0 && (m_pend[i] || unit_done[i])) g = i;
      if (|(unit_done & m_pvec())) e_err = 1;
      if (g >= 0) begin
         e_valid = 1;
         e_unit  = '0;
         e_unit[g] = 1'b1;
         e_data  = m_pend[g] ? m_data[g] : unit_data[XLEN*g +: XLEN];
         e_rd    = m_pend[g] ? m_rd[g] : unit_rd[5*g +: 5];
         e_fp    = m_pend[g] ? m_fp[g] : unit_fp[g];
         m_pend[g] = 0;
      end else begin
         e_valid = 0;
         e_unit  = '0;
      end
      for (int i = 0; i < 9; i++)
         if (i != g && !m_pend[i] && unit_done[i]) begin
            m_pend[i] = 1; m_since[i] = now;
            m_data[i] = unit_data[XLEN*i +: XLEN]; m_rd[i] = unit_rd[5*i +: 5]; m_fp[i] = unit_fp[i];
         end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rst_n) model_step();
      else model_reset();
   endtask

   task automatic set_u(input int i, input logic [XLEN-1:0] d, input logic [4:0] rd, input logic fp);
      unit_done[i] = 1'b1;
      unit_data[XLEN*i +: XLEN] = d;
      unit_rd[5*i +: 5] = rd;
      unit_fp[i] = fp;
   endtask

   always @(negedge clk)
      if (rst_n) begin
         chk("m_valid", 64'(wb_valid), 64'(e_valid));
         chk("m_unit", 64'(wb_unit), 64'(e_unit));
         chk("m_data", 64'(wb_data), 64'(e_data));
         chk("m_rd", 64'(wb_rd), 64'(e_rd));
         chk("m_fp", 64'(wb_fp), 64'(e_fp));
         chk("m_stall", 64'(unit_stall), 64'(m_pvec()));
         chk("m_err", 64'(proto_err), 64'(e_err));
      end

   initial begin
      model_reset();
      repeat (2) cyc();
      chk("rst_valid", 64'(wb_valid), 0);
      chk("rst_stall", 64'(unit_stall), 0);
      chk("rst_err", 64'(proto_err), 0);
      chk("rst_data", 64'(wb_data), 0);
      chk("rst_unit", 64'(wb_unit), 0);
      #2 rst_n = 1'b1;
      cyc();
      set_u(8, 32'h5, 5'd3, 1'b0);
      cyc();
      unit_done = '0;
      chk("alu_valid", 64'(wb_valid), 1);
      chk("alu_data", 64'(wb_data), 64'h5);
      chk("alu_rd", 64'(wb_rd), 3);
      chk("alu_unit", 64'(wb_unit), 64'h100);
      chk("alu_stall", 64'(unit_stall), 0);
      cyc();
      set_u(8, 32'h10, 5'd4, 1'b0);
      set_u(1, 32'h7, 5'd9, 1'b0);
      cyc();
      unit_done = '0;
      chk("pair1_unit", 64'(wb_unit), 64'h100);
      chk("pair1_stall", 64'(unit_stall), 64'h002);
      cyc();
      chk("pair2_unit", 64'(wb_unit), 64'h002);
      chk("pair2_data", 64'(wb_data), 64'h7);
      chk("pair2_rd", 64'(wb_rd), 9);
      chk("pair2_stall", 64'(unit_stall), 0);
      set_u(8, 32'h20, 5'd1, 1'b0);
      set_u(0, 32'h30, 5'd2, 1'b1);
      cyc();
      unit_done[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) cyc();
         chk("starve_unit", 64'(wb_unit), (k == 4) ? 64'h001 : 64'h100);
      end
      unit_done = '0;
      cyc();
      cyc();
      set_u(7, 32'h22, 5'd5, 1'b1);
      set_u(4, 32'h11, 5'd6, 1'b1);
      cyc();
      unit_done = '0;
      chk("proto_stall", 64'(unit_stall), 64'h010);
      chk("proto_unit0", 64'(wb_unit), 64'h080);
      set_u(4, 32'h99, 5'd7, 1'b0);
      cyc();
      unit_done = '0;
      chk("proto_unit", 64'(wb_unit), 64'h010);
      chk("proto_data", 64'(wb_data), 64'h11);
      chk("proto_rd", 64'(wb_rd), 6);
      chk("proto_err", 64'(proto_err), 1);
      cyc();
      chk("proto_sticky", 64'(proto_err), 1);
      chk("proto_idle", 64'(wb_valid), 0);
      for (int i = 0; i < 9; i++) set_u(i, XLEN'(32'h100 + i), 5'(i), logic'(i % 2));
      cyc();
      unit_done = '0;
      chk("all_first", 64'(wb_unit), 64'h100);
      repeat (10) cyc();
      chk("all_drained", 64'(unit_stall), 0);
      set_u(8, 32'h1, 5'd1, 1'b0);
      set_u(6, 32'h2, 5'd2, 1'b0);
      set_u(1, 32'h3, 5'd3, 1'b0);
      set_u(0, 32'h4, 5'd4, 1'b0);
      cyc();
      unit_done = '0;
      chk("arst_pre", 64'(unit_stall), 64'h043);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_stall", 64'(unit_stall), 0);
      chk("arst_valid", 64'(wb_valid), 0);
      chk("arst_err", 64'(proto_err), 0);
      cyc();
      #3 rst_n = 1'b1;
      cyc();
      cyc();
      chk("post_valid", 64'(wb_valid), 0);
      chk("post_stall", 64'(unit_stall), 0);
      chk("post_unit", 64'(wb_unit), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
